// File: rtl/tile_match_controller_if.sv
// tile_match_controller_if
//  Groups the pick handshake and the tile RAM read port of the tile match
//  controller.
//  Signals:
//   select_valid  pick strobe from the player input logic
//   select_idx    picked tile index
//   select_ready  controller can take a pick this cycle
//   rd_idx        tile RAM read address driven by the controller
//   rd_sym        tile RAM read data, one cycle behind rd_idx
//  Modports:
//   master  the side that makes picks and owns the tile RAM
//   slave   the controller itself
interface tile_match_controller_if #(
    parameter int IDX_W = 4,
    parameter int SYM_W = 3
);
    logic             select_valid;
    logic [IDX_W-1:0] select_idx;
    logic             select_ready;
    logic [IDX_W-1:0] rd_idx;
    logic [SYM_W-1:0] rd_sym;

    modport master (
        output select_valid, select_idx, rd_sym,
        input  select_ready, rd_idx
    );

    modport slave (
        input  select_valid, select_idx, rd_sym,
        output select_ready, rd_idx
    );
endinterface

// File: rtl/tile_match_controller.sv
// tile_match_controller
//  Runs one round of the tile matching game while the mode FSM reports
//  in-game. Two picks are taken per move, each tile's symbol is fetched from
//  the tile RAM, and the pair is either locked as matched or shown for
//  SHOW_CYCLES and then hidden again. Moves and matches are counted and
//  gameOver is raised once every pair is matched.
//  Ports:
//   CLOCK_50       system clock, all logic on the rising edge
//   resetn         synchronous active-low reset
//   ingameOn       high while the mode FSM is in its in-game state
//   bus            pick handshake and tile RAM read port (slave side)
//   revealed_mask  tiles currently face-up, matched tiles included
//   matched_mask   tiles locked as matched
//   match_count    pairs matched so far
//   move_count     pairs compared so far, saturating at 255
//   gameOver       high while every pair is matched and the game is still on
module tile_match_controller #(
    parameter int NUM_TILES   = 16,
    parameter int IDX_W       = 4,
    parameter int SYM_W       = 3,
    parameter int SHOW_CYCLES = 25_000_000
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  ingameOn,
    tile_match_controller_if.slave bus,
    output logic [NUM_TILES-1:0]  revealed_mask,
    output logic [NUM_TILES-1:0]  matched_mask,
    output logic [IDX_W-1:0]      match_count,
    output logic [7:0]            move_count,
    output logic                  gameOver
);

    localparam int TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE, WAIT_A, ADDR_A, CAP_A, WAIT_B, ADDR_B, CAP_B, CMP, SHOW, DONE
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idxA_q, idxB_q, rdIdx_q;
    logic [SYM_W-1:0]     symA_q, symB_q;
    logic [NUM_TILES-1:0] revealed_q, matched_q;
    logic [IDX_W-1:0]     matchCount_q;
    logic [7:0]           moveCount_q;
    logic [TMR_W-1:0]     timer_q;

    logic                 ready;
    logic                 pickOk;
    logic                 abort;
    logic [IDX_W-1:0]     matchCount_d;
    logic [7:0]           moveCount_d;

    // One-hot mask for a tile index; an out-of-range index shifts out to zero.
    function automatic logic [NUM_TILES-1:0] tileBit(input logic [IDX_W-1:0] idx);
        tileBit = {{(NUM_TILES-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign ready = (state_q == WAIT_A) || (state_q == WAIT_B);

    // A pick is taken only for an on-board, unmatched tile, and the second
    // pick of a move may not be the first tile again.
    assign pickOk = bus.select_valid && ready
                 && ({1'b0, bus.select_idx} < (IDX_W+1)'(NUM_TILES))
                 && ((matched_q & tileBit(bus.select_idx)) == '0)
                 && !((state_q == WAIT_B) && (bus.select_idx == idxA_q));

    // Dropping out of the game overrides everything except reset.
    assign abort = !ingameOn && (state_q != IDLE);

    assign matchCount_d = matchCount_q + IDX_W'(1);
    assign moveCount_d  = (moveCount_q == 8'hFF) ? 8'hFF : moveCount_q + 8'd1;

    // Game sequencer: pick A, fetch its symbol, pick B, fetch, compare, then
    // either lock the pair or hold it face-up until the show timer runs out.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q      <= IDLE;
            idxA_q       <= '0;
            idxB_q       <= '0;
            rdIdx_q      <= '0;
            symA_q       <= '0;
            symB_q       <= '0;
            revealed_q   <= '0;
            matched_q    <= '0;
            matchCount_q <= '0;
            moveCount_q  <= '0;
            timer_q      <= '0;
        end else if (abort) begin
            // Clear the board on the same edge so nothing stale survives re-entry.
            state_q      <= IDLE;
            revealed_q   <= '0;
            matched_q    <= '0;
            matchCount_q <= '0;
            moveCount_q  <= '0;
            timer_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    revealed_q   <= '0;
                    matched_q    <= '0;
                    matchCount_q <= '0;
                    moveCount_q  <= '0;
                    if (ingameOn) state_q <= WAIT_A;
                end
                WAIT_A: begin
                    if (pickOk) begin
                        idxA_q     <= bus.select_idx;
                        rdIdx_q    <= bus.select_idx;
                        revealed_q <= revealed_q | tileBit(bus.select_idx);
                        state_q    <= ADDR_A;
                    end
                end
                ADDR_A: state_q <= CAP_A;
                CAP_A: begin
                    symA_q  <= bus.rd_sym;
                    state_q <= WAIT_B;
                end
                WAIT_B: begin
                    if (pickOk) begin
                        idxB_q     <= bus.select_idx;
                        rdIdx_q    <= bus.select_idx;
                        revealed_q <= revealed_q | tileBit(bus.select_idx);
                        state_q    <= ADDR_B;
                    end
                end
                ADDR_B: state_q <= CAP_B;
                CAP_B: begin
                    symB_q  <= bus.rd_sym;
                    state_q <= CMP;
                end
                CMP: begin
                    moveCount_q <= moveCount_d;
                    if (symA_q == symB_q) begin
                        matched_q    <= matched_q | tileBit(idxA_q) | tileBit(idxB_q);
                        matchCount_q <= matchCount_d;
                        state_q      <= (matchCount_d == IDX_W'(NUM_TILES/2)) ? DONE : WAIT_A;
                    end else begin
                        // Counting down to zero inclusive keeps the pair up for SHOW_CYCLES.
                        timer_q <= TMR_W'(SHOW_CYCLES - 1);
                        state_q <= SHOW;
                    end
                end
                SHOW: begin
                    if (timer_q == '0) begin
                        revealed_q <= revealed_q & ~(tileBit(idxA_q) | tileBit(idxB_q));
                        state_q    <= WAIT_A;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                DONE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.select_ready = ready;
    assign bus.rd_idx       = rdIdx_q;
    assign revealed_mask    = revealed_q;
    assign matched_mask     = matched_q;
    assign match_count      = matchCount_q;
    assign move_count       = moveCount_q;
    assign gameOver         = (state_q == DONE);

endmodule

// File: tb/tb_tile_match_controller.sv
// tb_tile_match_controller
//  Drives tile_match_controller with a four-tile board (symbols 5,2,5,2) and a
//  four-cycle show time. A timeline model of the game predicts every output on
//  every cycle; a few literal expectations pin the model to known results.
module tb_tile_match_controller;

    localparam int NUM_TILES   = 4;
    localparam int IDX_W       = 2;
    localparam int SYM_W       = 3;
    localparam int SHOW_CYCLES = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 resetn;
    logic                 ingameOn;
    logic [NUM_TILES-1:0] revealedMask, matchedMask;
    logic [IDX_W-1:0]     matchCount;
    logic [7:0]           moveCount;
    logic                 gameOver;

    tile_match_controller_if #(.IDX_W(IDX_W), .SYM_W(SYM_W)) bus ();

    tile_match_controller #(
        .NUM_TILES(NUM_TILES), .IDX_W(IDX_W), .SYM_W(SYM_W), .SHOW_CYCLES(SHOW_CYCLES)
    ) dut (
        .CLOCK_50(clk),
        .resetn(resetn),
        .ingameOn(ingameOn),
        .bus(bus),
        .revealed_mask(revealedMask),
        .matched_mask(matchedMask),
        .match_count(matchCount),
        .move_count(moveCount),
        .gameOver(gameOver)
    );

    int ramSym [NUM_TILES] = '{5, 2, 5, 2};

    // Tile RAM with one cycle of read latency.
    always @(posedge clk) bus.rd_sym <= SYM_W'(ramSym[bus.rd_idx]);

    int tests    = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Timeline model: events are scheduled by cycle number from the moment a
    // pick is accepted rather than by walking through controller states.
    int                   cyc = 0;
    bit                   modelValid = 0;
    bit                   mActive, mReady, mWantB, mDone;
    int                   mA, mB, mRdIdx;
    int                   readyAt = -1, cmpAt = -1, hideAt = -1;
    logic [NUM_TILES-1:0] mRevealed, mMatched;
    int                   mMatches, mMoves;

    function automatic bit legalPick(input int idx);
        return (idx < NUM_TILES) && !mMatched[idx] && !(mWantB && idx == mA);
    endfunction

    task automatic clearGame();
        mRevealed = '0; mMatched = '0; mMatches = 0; mMoves = 0;
        mReady = 0; mWantB = 0; mDone = 0;
        readyAt = -1; cmpAt = -1; hideAt = -1;
    endtask

    always @(posedge clk) begin
        int idx;
        cyc++;
        idx = int'(bus.select_idx);
        if (!resetn) begin
            modelValid = 1;
            clearGame();
            mActive = 0;
            mRdIdx  = 0;
        end else if (!ingameOn) begin
            clearGame();
            mActive = 0;
        end else if (!mActive) begin
            clearGame();
            mActive = 1;
            mReady  = 1;
        end else if (mReady && bus.select_valid && legalPick(idx)) begin
            mRevealed[idx] = 1'b1;
            mRdIdx = idx;
            mReady = 0;
            if (!mWantB) begin
                mA = idx; mWantB = 1; readyAt = cyc + 2;
            end else begin
                mB = idx; mWantB = 0; cmpAt = cyc + 3;
            end
        end else if (cyc == cmpAt) begin
            cmpAt = -1;
            if (mMoves < 255) mMoves++;
            if (ramSym[mA] == ramSym[mB]) begin
                mMatched[mA] = 1'b1;
                mMatched[mB] = 1'b1;
                mMatches++;
                if (mMatches == NUM_TILES/2) mDone = 1;
                else mReady = 1;
            end else begin
                hideAt = cyc + SHOW_CYCLES;
            end
        end else if (cyc == hideAt) begin
            hideAt = -1;
            mRevealed[mA] = 1'b0;
            mRevealed[mB] = 1'b0;
            mReady = 1;
        end else if (cyc == readyAt) begin
            readyAt = -1;
            mReady = 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("select_ready",  32'(bus.select_ready), 32'(mReady));
            checkOutput("rd_idx",        32'(bus.rd_idx),       32'(mRdIdx));
            checkOutput("revealed_mask", 32'(revealedMask),     32'(mRevealed));
            checkOutput("matched_mask",  32'(matchedMask),      32'(mMatched));
            checkOutput("match_count",   32'(matchCount),       32'(mMatches));
            checkOutput("move_count",    32'(moveCount),        32'(mMoves));
            checkOutput("gameOver",      32'(gameOver),         32'(mDone));
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a pick for a number of cycles regardless of select_ready.
    task automatic applyStimulus(input int idx, input int cycles);
        bus.select_valid = 1'b1;
        bus.select_idx   = IDX_W'(idx);
        repeat (cycles) @(negedge clk);
        bus.select_valid = 1'b0;
    endtask

    // Wait (bounded) until the controller can take a pick, then present it once.
    task automatic pickTile(input int idx);
        int waited = 0;
        while (!bus.select_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            tests++;
            failures++;
            $display("[TB] FAIL pick timeout: select_ready low for %0d cycles, expected high within 50", waited);
        end
        applyStimulus(idx, 1);
    endtask

    task automatic restartGame();
        ingameOn = 1'b0;
        @(negedge clk);
        ingameOn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #600_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn           = 1'b0;
        ingameOn         = 1'b0;
        bus.select_valid = 1'b0;
        bus.select_idx   = '0;
        waitCycles(2);

        $display("[TB] reset state");
        checkOutput("reset revealed", 32'(revealedMask), 32'h0);
        checkOutput("reset matched",  32'(matchedMask),  32'h0);
        checkOutput("reset moves",    32'(moveCount),    32'h0);
        checkOutput("reset ready",    32'(bus.select_ready), 32'h0);
        checkOutput("reset gameOver", 32'(gameOver),     32'h0);

        $display("[TB] matching pair 0/2");
        resetn   = 1'b1;
        ingameOn = 1'b1;
        @(negedge clk);
        pickTile(0);
        pickTile(2);
        waitCycles(3);
        checkOutput("match1 matched",  32'(matchedMask), 32'h5);
        checkOutput("match1 count",    32'(matchCount),  32'h1);
        checkOutput("match1 moves",    32'(moveCount),   32'h1);
        checkOutput("match1 gameOver", 32'(gameOver),    32'h0);

        $display("[TB] mismatched pair 0/1 is shown then hidden");
        restartGame();
        pickTile(0);
        pickTile(1);
        waitCycles(3);
        for (int i = 0; i < SHOW_CYCLES; i++) begin
            checkOutput("show revealed", 32'(revealedMask), 32'h3);
            checkOutput("show ready",    32'(bus.select_ready), 32'h0);
            @(negedge clk);
        end
        checkOutput("hidden revealed", 32'(revealedMask), 32'h0);
        checkOutput("hidden moves",    32'(moveCount),    32'h1);

        $display("[TB] illegal picks and full game");
        pickTile(1);
        pickTile(3);
        waitCycles(3);
        checkOutput("match 1/3 matched", 32'(matchedMask), 32'hA);
        applyStimulus(1, 1);
        checkOutput("matched pick revealed", 32'(revealedMask), 32'hA);
        checkOutput("matched pick rd_idx",   32'(bus.rd_idx),   32'h3);
        pickTile(0);
        pickTile(0);
        checkOutput("repeat pick revealed", 32'(revealedMask), 32'hB);
        checkOutput("repeat pick ready",    32'(bus.select_ready), 32'h1);
        applyStimulus(3, 1);
        pickTile(2);
        waitCycles(3);
        checkOutput("done gameOver", 32'(gameOver),    32'h1);
        checkOutput("done matched",  32'(matchedMask), 32'hF);
        checkOutput("done count",    32'(matchCount),  32'h2);
        checkOutput("done moves",    32'(moveCount),   32'h3);
        waitCycles(5);
        checkOutput("done hold", 32'(gameOver), 32'h1);
        ingameOn = 1'b0;
        @(negedge clk);
        checkOutput("abort gameOver", 32'(gameOver),    32'h0);
        checkOutput("abort matched",  32'(matchedMask), 32'h0);
        checkOutput("abort moves",    32'(moveCount),   32'h0);

        $display("[TB] pick during show is ignored");
        ingameOn = 1'b1;
        @(negedge clk);
        pickTile(0);
        pickTile(1);
        waitCycles(4);
        applyStimulus(2, 2);
        checkOutput("show pick revealed", 32'(revealedMask), 32'h3);
        checkOutput("show pick rd_idx",   32'(bus.rd_idx),   32'h1);
        waitCycles(1);
        checkOutput("show end revealed", 32'(revealedMask), 32'h0);

        $display("[TB] reset during show, abort in ADDR_B");
        pickTile(0);
        pickTile(1);
        waitCycles(4);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midshow reset revealed", 32'(revealedMask), 32'h0);
        checkOutput("midshow reset ready",    32'(bus.select_ready), 32'h0);
        checkOutput("midshow reset rd_idx",   32'(bus.rd_idx),   32'h0);
        checkOutput("midshow reset moves",    32'(moveCount),    32'h0);
        resetn = 1'b1;
        @(negedge clk);
        pickTile(2);
        checkOutput("reentry revealed", 32'(revealedMask), 32'h4);
        pickTile(3);
        ingameOn = 1'b0;
        @(negedge clk);
        checkOutput("addrB abort revealed", 32'(revealedMask), 32'h0);
        checkOutput("addrB abort ready",    32'(bus.select_ready), 32'h0);
        ingameOn = 1'b1;
        @(negedge clk);
        pickTile(1);
        checkOutput("abort reentry revealed", 32'(revealedMask), 32'h2);

        $display("[TB] move counter saturation");
        restartGame();
        for (int i = 0; i < 260; i++) begin
            pickTile(0);
            pickTile(1);
        end
        waitCycles(8);
        checkOutput("saturated moves", 32'(moveCount),  32'd255);
        checkOutput("saturated count", 32'(matchCount), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
